// File: rtl/sbc_limb_sequencer.sv
// Serial 2-bit-limb subtract-with-carry sequencer, LSB limb first.
// One output register stage; IN_READY back-pressures through that stage.
module sbc_limb_sequencer #(
  parameter int unsigned NLIMBS = 4
) (
  input  logic       CLKIN,
  input  logic       RESETN,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       CIN,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [1:0] D,
  output logic       OUT_LAST,
  output logic       BORROW,
  output logic       ZERO
);

  localparam int unsigned CNT_W = (NLIMBS > 2) ? $clog2(NLIMBS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NLIMBS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       diff_q, diff_d;
  logic             last_q, last_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  logic             in_ready_c;
  logic             in_xfer;
  logic             out_xfer;
  logic             first_limb;
  logic             cin_sel;
  logic [2:0]       sum;
  logic             zacc_new;

  // Limb arithmetic and handshake decode
  always_comb begin
    in_ready_c = !out_valid_q || OUT_READY;
    in_xfer    = IN_VALID && in_ready_c;
    out_xfer   = out_valid_q && OUT_READY;
    first_limb = (cnt_q == '0);
    cin_sel    = first_limb ? CIN : carry_q;
    sum        = {1'b0, A} + {1'b0, ~B} + {2'b00, cin_sel};
    // Limb 0 restarts the zero accumulation regardless of the previous operand
    zacc_new   = (first_limb || zacc_q) && (sum[1:0] == 2'b00);
  end

  // Next-state: load on input transfer, otherwise drain or hold
  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    zacc_d      = zacc_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    last_d      = last_q;
    borrow_d    = borrow_q;
    zero_d      = zero_q;
    if (in_xfer) begin
      cnt_d       = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
      carry_d     = sum[2];
      zacc_d      = zacc_new;
      out_valid_d = 1'b1;
      diff_d      = sum[1:0];
      last_d      = (cnt_q == LAST_IDX);
      borrow_d    = !sum[2];
      zero_d      = zacc_new;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= 2'b00;
      last_q      <= 1'b0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      zacc_q      <= zacc_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      last_q      <= last_d;
      borrow_q    <= borrow_d;
      zero_q      <= zero_d;
    end
  end

  assign IN_READY  = in_ready_c;
  assign OUT_VALID = out_valid_q;
  assign D         = diff_q;
  assign OUT_LAST  = last_q;
  assign BORROW    = borrow_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_sbc_limb_sequencer.sv
// Scoreboard bench for sbc_limb_sequencer: operand-level reference model,
// per-limb expectations queued at input transfer and checked at output transfer.
module tb_sbc_limb_sequencer;

  localparam int unsigned NLIMBS = 4;
  localparam int unsigned W      = 2 * NLIMBS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } op_t;

  typedef struct {
    logic [1:0] d;
    logic       last;
    logic       borrow;
    logic       zero;
  } exp_t;

  logic       CLKIN = 1'b0;
  logic       RESETN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [1:0] A;
  logic [1:0] B;
  logic       CIN;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [1:0] D;
  logic       OUT_LAST;
  logic       BORROW;
  logic       ZERO;

  sbc_limb_sequencer #(.NLIMBS(NLIMBS)) dut (
    .CLKIN    (CLKIN),
    .RESETN   (RESETN),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
    .CIN      (CIN),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .D        (D),
    .OUT_LAST (OUT_LAST),
    .BORROW   (BORROW),
    .ZERO     (ZERO)
  );

  always #5 CLKIN = ~CLKIN;

  op_t  ops[$];
  exp_t expq[$];
  int   idx;
  int   acc_cnt;
  int   vpct;
  int   rpct;
  bit   force_stall;
  int   n_vec;
  int   n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: new inputs shortly after each rising edge
  initial begin
    IN_VALID  = 1'b0;
    A         = 2'b00;
    B         = 2'b00;
    CIN       = 1'b0;
    OUT_READY = 1'b0;
    forever begin
      @(posedge CLKIN);
      #1;
      OUT_READY = force_stall ? 1'b0 : (32'($urandom_range(99)) < 32'(rpct));
      if (ops.size() > 0 && 32'($urandom_range(99)) < 32'(vpct)) begin
        IN_VALID = 1'b1;
        A        = ops[0].a[2*idx +: 2];
        B        = ops[0].b[2*idx +: 2];
        CIN      = (idx == 0) ? ops[0].cin : 1'($urandom_range(1));
      end else begin
        IN_VALID = 1'b0;
        A        = 2'($urandom_range(3));
        B        = 2'($urandom_range(3));
        CIN      = 1'($urandom_range(1));
      end
    end
  end

  // Monitor on the falling edge: values here are what the next rising edge samples
  initial begin
    bit         prev_rst;
    bit         prev_stall;
    bit         prev_acc;
    logic [4:0] held;
    exp_t       e;
    op_t        op;
    logic [W-1:0] diff;
    logic [W:0]   rhs;
    prev_rst   = 1'b0;
    prev_stall = 1'b0;
    prev_acc   = 1'b0;
    held       = '0;
    forever begin
      @(negedge CLKIN);
      if (!RESETN) begin
        if (prev_rst) begin
          check("rst_out_valid", 32'(OUT_VALID), 32'd0);
          check("rst_d", 32'(D), 32'd0);
          check("rst_last", 32'(OUT_LAST), 32'd0);
          check("rst_borrow", 32'(BORROW), 32'd0);
          check("rst_zero", 32'(ZERO), 32'd0);
          check("rst_in_ready", 32'(IN_READY), 32'd1);
        end
        if (idx != 0) void'(ops.pop_front());
        idx = 0;
        expq.delete();
        prev_rst   = 1'b1;
        prev_stall = 1'b0;
        prev_acc   = 1'b0;
      end else begin
        prev_rst = 1'b0;
        check("in_ready", 32'(IN_READY), 32'(!OUT_VALID || OUT_READY));
        if (prev_acc) check("latency", 32'(OUT_VALID), 32'd1);
        if (prev_stall) check("stall_hold", 32'({OUT_VALID, D, OUT_LAST, BORROW, ZERO}),
                              32'({1'b1, held}));
        prev_stall = OUT_VALID && !OUT_READY;
        held       = {D, OUT_LAST, BORROW, ZERO};
        if (OUT_VALID && OUT_READY) begin
          if (expq.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            check("d", 32'(D), 32'(e.d));
            check("last", 32'(OUT_LAST), 32'(e.last));
            if (e.last) begin
              check("borrow", 32'(BORROW), 32'(e.borrow));
              check("zero", 32'(ZERO), 32'(e.zero));
            end
          end
        end
        prev_acc = IN_VALID && IN_READY;
        if (IN_VALID && IN_READY) begin
          op     = ops[0];
          diff   = op.a - op.b - W'(!op.cin);
          rhs    = {1'b0, op.b} + (W+1)'(!op.cin);
          e.d      = diff[2*idx +: 2];
          e.last   = (idx == NLIMBS - 1);
          e.borrow = ({1'b0, op.a} < rhs);
          e.zero   = (diff == '0);
          expq.push_back(e);
          acc_cnt++;
          idx++;
          if (idx == NLIMBS) begin
            idx = 0;
            void'(ops.pop_front());
          end
        end
      end
    end
  end

  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    op_t o;
    o.a   = a;
    o.b   = b;
    o.cin = cin;
    ops.push_back(o);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((ops.size() != 0 || expq.size() != 0) && n < budget) begin
      @(posedge CLKIN);
      n++;
    end
    if (n >= budget) check(tag, 32'(ops.size() + expq.size()), 32'd0);
    repeat (2) @(posedge CLKIN);
  endtask

  task automatic wait_acc(input string tag, input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < 200) begin
      @(posedge CLKIN);
      #1;
      n++;
    end
    if (n >= 200) check(tag, 32'(acc_cnt), 32'(target));
  endtask

  task automatic do_reset(input int cycles);
    @(posedge CLKIN);
    #1;
    RESETN = 1'b0;
    repeat (cycles) @(posedge CLKIN);
    #1;
    RESETN = 1'b1;
  endtask

  initial begin
    int acc0;
    n_vec       = 0;
    n_err       = 0;
    idx         = 0;
    acc_cnt     = 0;
    vpct        = 100;
    rpct        = 100;
    force_stall = 1'b0;
    RESETN      = 1'b0;
    repeat (3) @(posedge CLKIN);
    #1;
    RESETN = 1'b1;

    // Directed operands, full throughput
    push_op(8'h35, 8'h12, 1'b1);
    push_op(8'h12, 8'h35, 1'b1);
    push_op(8'h5A, 8'h5A, 1'b1);
    push_op(8'h5A, 8'h5A, 1'b0);
    drain("drain_directed", 200);

    // Back-to-back operands with a 3-cycle downstream stall mid-stream
    acc0 = acc_cnt;
    push_op(8'h35, 8'h12, 1'b1);
    push_op(8'hA7, 8'h3C, 1'b0);
    wait_acc("wait_stall", acc0 + 2);
    force_stall = 1'b1;
    repeat (3) @(posedge CLKIN);
    force_stall = 1'b0;
    drain("drain_stall", 200);

    // Reset after two limbs, then a full operand
    acc0 = acc_cnt;
    push_op(8'h35, 8'h12, 1'b1);
    wait_acc("wait_reset", acc0 + 2);
    RESETN = 1'b0;
    repeat (2) @(posedge CLKIN);
    #1;
    RESETN = 1'b1;
    push_op(8'h12, 8'h35, 1'b1);
    drain("drain_reset", 200);

    // Random operands with random handshake toggling
    vpct = 70;
    rpct = 70;
    for (int i = 0; i < 1000; i++)
      push_op(W'($urandom), W'($urandom), 1'($urandom_range(1)));
    drain("drain_random", 40000);

    do_reset(2);
    repeat (2) @(posedge CLKIN);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sbc_limb_sequencer.md
SBC_LIMB_SEQUENCER -- requirements
Module: sbc_limb_sequencer

Interface
REQ-001 Parameter NLIMBS, default 4, SHALL set the number of 2-bit limbs per operand (operand width 2*NLIMBS; legal range 2..16).
REQ-002 CLKIN  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RESETN  input  1  SHALL be the synchronous, active-low reset.
REQ-004 IN_VALID  input  1  SHALL qualify A, B and CIN as one limb offered by the upstream.
REQ-005 IN_READY  output  1  SHALL indicate the block accepts a limb this cycle.
REQ-006 A  input  2  SHALL carry the minuend limb, least-significant limb first.
REQ-007 B  input  2  SHALL carry the subtrahend limb, least-significant limb first.
REQ-008 CIN  input  1  SHALL carry the initial carry; sampled only on limb 0 of an operand (1 = plain subtract, 0 = subtract with borrow-in).
REQ-009 OUT_VALID  output  1  SHALL qualify D, OUT_LAST, BORROW and ZERO.
REQ-010 OUT_READY  input  1  SHALL indicate the downstream takes the output limb this cycle.
REQ-011 D  output  2  SHALL carry the difference limb.
REQ-012 OUT_LAST  output  1  SHALL mark the final (most-significant) limb of an operand.
REQ-013 BORROW  output  1  SHALL give the inverted final carry; meaningful only when OUT_LAST=1.
REQ-014 ZERO  output  1  SHALL be 1 when all limbs of the operand were 00; meaningful only when OUT_LAST=1.

Function
REQ-015 An input limb SHALL transfer when IN_VALID && IN_READY; an output limb SHALL transfer when OUT_VALID && OUT_READY.
REQ-016 IN_READY SHALL equal !OUT_VALID || OUT_READY (single output register, no combinational path from IN_VALID to OUT_VALID).
REQ-017 Per limb: cin = (limb counter == 0) ? CIN : carry register; {cout, D} = A + ~B + cin, 3-bit arithmetic.
REQ-018 Latency SHALL be exactly 1 cycle: a limb accepted in cycle N appears on D with OUT_VALID=1 in cycle N+1.
REQ-019 The limb counter SHALL increment on each input transfer and wrap from NLIMBS-1 to 0; the carry register SHALL load cout on each input transfer.
REQ-020 OUT_LAST SHALL be registered as (counter == NLIMBS-1) at input transfer.
REQ-021 ZERO accumulator SHALL restart with the limb-0 result and AND-in (result==00) for each later limb; ZERO output is the accumulated value including the current limb.
REQ-022 BORROW output SHALL equal !cout of the current limb.
REQ-023 With OUT_VALID=1 and OUT_READY=0, all outputs SHALL hold stable and IN_READY SHALL be 0.
REQ-024 Simultaneous output and input transfer in one cycle SHALL load the new limb with no bubble (full throughput, one limb per cycle).
REQ-025 Gaps in IN_VALID mid-operand SHALL NOT disturb counter, carry or ZERO state.
REQ-026 CIN on limbs 1..NLIMBS-1 SHALL be ignored.

Reset
REQ-027 With RESETN=0 at a rising edge: OUT_VALID=0, D=00, OUT_LAST=0, BORROW=0, ZERO=0, counter=0, carry register=0, ZERO accumulator=1.
REQ-028 IN_READY SHALL be 1 during and after reset (follows REQ-016).
REQ-029 Reset mid-operand SHALL discard the partial operand; the next accepted limb is limb 0.

Verification (NLIMBS=4, limbs listed LSB first)
REQ-030 A=0x35 (01,01,11,00), B=0x12 (10,00,01,00), CIN=1, OUT_READY=1 -> D=11,00,10,00 (0x23), OUT_LAST only on 4th, BORROW=0, ZERO=0.
REQ-031 A=0x12, B=0x35, CIN=1 -> D=0xDD (01,11,01,11), BORROW=1, ZERO=0.
REQ-032 A=B=0x5A, CIN=1 -> D=0x00, ZERO=1, BORROW=0; same with CIN=0 -> D=0xFF, ZERO=0, BORROW=1.
REQ-033 Two back-to-back operands with IN_VALID held 1 and OUT_READY held 0 for 3 cycles mid-stream -> D held stable, IN_READY=0 while stalled, no limb lost or duplicated, second operand uses its own CIN.
REQ-034 RESETN=0 after 2 limbs of 0x35-0x12, then full 0x12-0x35 -> outputs at reset values, then D=0xDD with BORROW=1, OUT_LAST on 4th limb after reset.
REQ-035 Random IN_VALID/OUT_READY toggling over 1000 random operand pairs -> every result matches (A - B - !CIN) mod 256 with BORROW = (A < B + !CIN).
